// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared constants and round-robin pick helper for the SDRAM arbiter
package sdram_arb_pkg;
  localparam int MAX_NREQ = 4;
  localparam int ID_W     = $clog2(MAX_NREQ);

  function automatic int outst_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Scans from the highest offset down so the first eligible slot at/after ptr wins.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid_vec,
                                                  input logic [ID_W-1:0]     ptr,
                                                  input int                  n);
    logic [MAX_NREQ-1:0] grant;
    logic [ID_W-1:0]     sel;
    grant = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      sel = ID_W'((int'(ptr) + k) % n);
      if (k < n && valid_vec[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
      end
    end
    return grant;
  endfunction
endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester and controller bus bundle for the SDRAM arbiter
interface sdram_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_we;
  logic [NREQ*ADDR_W-1:0]   req_addr;
  logic [NREQ*DATA_W-1:0]   req_wdata;
  logic [NREQ*DATA_W/8-1:0] req_wmask;
  logic [NREQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     mem_valid;
  logic                     mem_ready;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W/8-1:0]      mem_wmask;
  logic                     mem_rvalid;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/sdram_arb_idfifo.sv
// rtl/sdram_arb_idfifo.sv - in-order requester-ID FIFO for outstanding reads
module sdram_arb_idfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin sharing of one SDRAM controller port with in-order read return
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sdram_arbiter_if.slave             bus,
  output logic [$clog2(MAX_OUTST):0] outst,
  output logic                       err_unexp
);
  localparam int OUTST_W = outst_w(MAX_OUTST);
  localparam int MW      = DATA_W / 8;

  logic [NREQ-1:0]     elig, grant;
  logic [MAX_NREQ-1:0] elig_pad, pick;
  logic                slot_free, fifo_room, accept, push, pop;
  logic [ID_W-1:0]     win, fifo_dout;
  logic [OUTST_W-1:0]  fifo_count;

  logic                mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]       mem_wmask_q, mem_wmask_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                err_unexp_q, err_unexp_d;

  // A response popping this cycle frees a slot for a read accepted in the same cycle.
  always_comb begin
    slot_free = !mem_valid_q || bus.mem_ready;
    pop       = bus.mem_rvalid && (fifo_count != '0);
    fifo_room = (fifo_count < OUTST_W'(MAX_OUTST)) || bus.mem_rvalid;
    elig      = bus.req_valid & (bus.req_we | {NREQ{fifo_room}});
    elig_pad  = '0;
    elig_pad[NREQ-1:0] = elig;
    pick      = rr_pick(elig_pad, rr_ptr_q, NREQ);
    grant     = slot_free ? pick[NREQ-1:0] : '0;
    accept    = slot_free && (|pick);
    win       = '0;
    push      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win  = ID_W'(i);
        push = !bus.req_we[i];
      end
    end
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      mem_valid_d = 1'b1;
      rr_ptr_d    = ID_W'((int'(win) + 1) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          mem_we_d    = bus.req_we[i];
          mem_addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.req_wdata[i*DATA_W +: DATA_W];
          mem_wmask_d = bus.req_wmask[i*MW +: MW];
        end
      end
    end else if (bus.mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    err_unexp_d = err_unexp_q || (bus.mem_rvalid && fifo_count == '0);
    if (pop) begin
      rsp_rdata_d = bus.mem_rdata;
      for (int i = 0; i < NREQ; i++) begin
        if (fifo_dout == ID_W'(i)) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  sdram_arb_idfifo #(.DEPTH(MAX_OUTST), .W(ID_W)) u_idfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (win),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign bus.req_ready = grant;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign outst         = fifo_count;
  assign err_unexp     = err_unexp_q;
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port (mt48lc32m8a2 behind it) between NREQ requesters, e.g. MicroBlaze IO bus bridge and a DMA/PDM sample fetcher.
- Per-transaction round-robin arbitration with a registered command stage toward the controller.
- Read responses are routed back to their issuer through an in-order requester-ID FIFO.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 23, word address width (32M x 8 device = 8M 32-bit words)
- DATA_W, 32, data width; DATA_W/8 byte-mask bits
- MAX_OUTST, 4, maximum reads accepted but not yet answered (power of 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester command accepted this cycle
- req_we  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data
- req_wmask  in  NREQ*DATA_W/8  packed byte enables
- rsp_valid  out  NREQ  one-hot read-data valid
- rsp_rdata  out  DATA_W  read data, broadcast to all requesters
- mem_valid  out  1  command to controller valid
- mem_ready  in  1  controller accepts command
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  command fields
- mem_rvalid  in  1  read data returned, strictly in issue order
- mem_rdata  in  DATA_W  read data
- outst  out  $clog2(MAX_OUTST)+1  current outstanding read count
- err_unexp  out  1  sticky: mem_rvalid seen with no outstanding read

Behaviour:
- Reset (rst_n low at clk edge) values:
  - mem_valid=0, rsp_valid=0, outst=0, err_unexp=0
  - RR pointer=0; ID FIFO emptied; mem_* and rsp_rdata data fields 0
- Reset mid-operation: in-flight command and all outstanding reads are dropped. The controller shares rst_n; a late mem_rvalid is not routed.
- Eligibility of requester i: req_valid[i] && (req_we[i] || fifo_room).
  - fifo_room = outst<MAX_OUTST || mem_rvalid (pop same cycle frees a slot).
- Command slot is free when !mem_valid || mem_ready.
- Grant: combinational. First eligible index at or after rr_ptr, wrapping modulo NREQ. At most one bit of req_ready is high, and only while the slot is free.
- Accept (req_valid&req_ready):
  - Fields are registered into mem_* next clk; mem_valid=1 next cycle (1-cycle latency).
  - rr_ptr <= (winner+1) mod NREQ.
  - Reads push the winner ID into the FIFO at acceptance.
- Backpressure: mem_valid and all mem_* fields held stable while mem_ready=0. No new grant until mem_ready.
- Simultaneous mem_ready and a new accept: back-to-back issue with no bubble.
- Ineligible requester blocked by full FIFO is skipped; rr_ptr is not advanced for it. Writes from others proceed.
- Fairness: each continuously eligible requester is granted within NREQ grants.
- Response:
  - On mem_rvalid with outst>0: pop head ID k.
  - Next cycle: rsp_valid[k]=1 for 1 cycle, rsp_rdata=mem_rdata registered.
  - No backpressure on responses.
- Push and pop in the same cycle: outst unchanged, FIFO order preserved, including when full.
- mem_rvalid with outst=0: no pop, no rsp_valid; err_unexp set until reset.
- FIFO pointers wrap modulo MAX_OUTST; outst counts 0..MAX_OUTST inclusive.

Decomposition:
- Package sdram_arb_pkg:
  - ID_W=$clog2(NREQ) and OUTST_W constants
  - function rr_pick(valid_vec, ptr) returning a one-hot grant
- Sub-module sdram_arb_idfifo: sync FIFO of ID_W entries, depth MAX_OUTST.
  - Ports: push, pop, din, dout, count.
  - Same-cycle push/pop is legal when full.

Test Plan:
- Single read: req0 read addr 0x000123, mem_ready=1, controller returns 0xDEADBEEF 5 cycles later -> mem_valid at cycle+1 with addr 0x000123; rsp_valid=2'b01 and rsp_rdata=0xDEADBEEF one cycle after mem_rvalid.
- Contention: both requesters continuously valid with writes, mem_ready=1 -> grants alternate 0,1,0,1 for 8 accepts; no cycle with both req_ready bits high.
- FIFO full: MAX_OUTST=4, req0 issues 4 reads with no mem_rvalid -> outst=4, req0 stalls while req1 writes are still accepted. Then mem_rvalid together with req0's 5th read -> accepted same cycle, outst stays 4.
- Backpressure: mem_ready=0 for 10 cycles after a write of 0xA5A5A5A5/mask 0xF -> mem_* stable for all 10 cycles, req_ready=0; accept completes on the cycle mem_ready=1.
- Ordering: reads req0, req1, req0 issued, three mem_rvalid with data 1, 2, 3 -> rsp_valid sequence 01, 10, 01 with data 1, 2, 3.
- Reset mid-op: 2 reads outstanding, rst_n low 1 cycle -> outst=0, mem_valid=0. A following mem_rvalid produces no rsp_valid and sets err_unexp=1.
